// File: rtl/instr_mem_loader_pkg.sv
// ============================================================================
// Module   : instr_mem_loader_pkg
// Purpose  : Shared state encoding, MIPS opcode constants and width constants
//            for the instruction-memory program loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_mem_loader_pkg;

    localparam int c_DATA_WIDTH     = 32;
    localparam int c_BYTE_WIDTH     = 8;
    localparam int c_BYTES_PER_WORD = c_DATA_WIDTH / c_BYTE_WIDTH;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE = 3'd0;
    localparam state_t c_ST_LEN  = 3'd1;
    localparam state_t c_ST_DATA = 3'd2;
    localparam state_t c_ST_CSUM = 3'd3;
    localparam state_t c_ST_ERR  = 3'd4;

    // Opcode field [31:26], shared with the opcode/funct decoder
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_JUMP  = 6'h02;

    function automatic logic is_rx_state(input state_t st);
        return (st == c_ST_LEN) || (st == c_ST_DATA) || (st == c_ST_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_byte_to_word_packer.sv
// ============================================================================
// Module   : instr_mem_loader_byte_to_word_packer
// Purpose  : Assembles big-endian words from accepted stream bytes and emits
//            a registered one-cycle word strobe after each fourth byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader_byte_to_word_packer
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH_P = 32,
    parameter int BYTE_WIDTH_P = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_accept,
    input  logic [BYTE_WIDTH_P-1:0] i_byte,
    output logic                    o_word_done,
    output logic                    o_word_valid,
    output logic [DATA_WIDTH_P-1:0] o_word
);

    localparam logic [1:0] c_LAST_IDX = 2'(c_BYTES_PER_WORD - 1);

    logic [1:0]                           r_idx;
    logic [DATA_WIDTH_P-BYTE_WIDTH_P-1:0] r_shift;
    logic                                 r_word_valid;
    logic [DATA_WIDTH_P-1:0]              r_word;
    logic [DATA_WIDTH_P-1:0]              w_word;
    logic                                 w_word_done;

    // Earlier bytes sit in the upper bits, so the first byte lands in [31:24]
    assign w_word      = {r_shift, i_byte};
    assign w_word_done = i_accept && (r_idx == c_LAST_IDX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx        <= 2'd0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= w_word_done;
            if (w_word_done) begin
                r_word <= w_word;
            end
            if (i_clear) begin
                r_idx   <= 2'd0;
                r_shift <= '0;
            end else if (i_accept) begin
                r_idx   <= r_idx + 2'd1;
                r_shift <= w_word[DATA_WIDTH_P-BYTE_WIDTH_P-1:0];
            end
        end
    end

    assign o_word_done  = w_word_done;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Length-prefixed byte-stream program loader writing big-endian
//            MIPS words to instruction memory from address 0.
//            Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH_P = 32,
    parameter int BYTE_WIDTH_P = 8,
    parameter int ADDR_WIDTH_P = 8,
    parameter int LEN_WIDTH_P  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [BYTE_WIDTH_P-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_rx_ready,
    output logic                    o_imem_wr_en,
    output logic [ADDR_WIDTH_P-1:0] o_imem_wr_addr,
    output logic [DATA_WIDTH_P-1:0] o_imem_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error
);

    // Memory depth 2^ADDR_WIDTH_P in the widened word-count domain
    localparam logic [LEN_WIDTH_P:0] c_MAX_WORDS =
        {{(LEN_WIDTH_P-ADDR_WIDTH_P){1'b0}}, 1'b1, {ADDR_WIDTH_P{1'b0}}};
    localparam logic [LEN_WIDTH_P:0]  c_CNT_ONE  = (LEN_WIDTH_P+1)'(1);
    localparam logic [ADDR_WIDTH_P-1:0] c_ADDR_ONE = ADDR_WIDTH_P'(1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_rx_ready;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_error;
    logic                            r_len_phase;
    logic [LEN_WIDTH_P-BYTE_WIDTH_P-1:0] r_len_hi;
    logic [LEN_WIDTH_P-1:0]          r_len;
    logic [LEN_WIDTH_P:0]            r_word_cnt;
    logic [ADDR_WIDTH_P-1:0]         r_addr;

    logic                            w_accept;
    logic                            w_start;
    logic                            w_done_nxt;
    logic [LEN_WIDTH_P-1:0]          w_len_full;
    logic [LEN_WIDTH_P:0]            w_word_cnt_inc;
    logic                            w_word_done;
    logic                            w_wr_en;
    logic [DATA_WIDTH_P-1:0]         w_wr_data;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH_P-1:0]         r_csum;
`endif

    assign w_accept       = i_rx_valid && r_rx_ready;
    assign w_start        = i_start && ((r_state == c_ST_IDLE) || (r_state == c_ST_ERR));
    assign w_len_full     = {r_len_hi, i_rx_data};
    assign w_word_cnt_inc = r_word_cnt + c_CNT_ONE;

    instr_mem_loader_byte_to_word_packer #(
        .DATA_WIDTH_P (DATA_WIDTH_P),
        .BYTE_WIDTH_P (BYTE_WIDTH_P)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start),
        .i_accept     (w_accept && (r_state == c_ST_DATA)),
        .i_byte       (i_rx_data),
        .o_word_done  (w_word_done),
        .o_word_valid (w_wr_en),
        .o_word       (w_wr_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_ERR: begin
                if (i_start) begin
                    w_state_nxt = c_ST_LEN;
                end
            end
            c_ST_LEN: begin
                if (w_accept && r_len_phase) begin
                    if (w_len_full == '0) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if ({1'b0, w_len_full} > c_MAX_WORDS) begin
                        w_state_nxt = c_ST_ERR;
                    end else begin
                        w_state_nxt = c_ST_DATA;
                    end
                end
            end
            c_ST_DATA: begin
                if (w_word_done && (w_word_cnt_inc == {1'b0, r_len})) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_nxt = c_ST_CSUM;
`else
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            c_ST_CSUM: begin
                if (w_accept) begin
                    if (i_rx_data == r_csum) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_ERR;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_rx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_len_phase <= 1'b0;
            r_len_hi    <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_addr      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= is_rx_state(w_state_nxt);
            // Busy lingers one cycle on a successful finish so it covers o_done
            r_busy     <= is_rx_state(w_state_nxt) ||
                          (is_rx_state(r_state) && (w_state_nxt == c_ST_IDLE));
            r_done     <= w_done_nxt;
            r_error    <= (w_state_nxt == c_ST_ERR);

            if (w_accept && (r_state == c_ST_LEN)) begin
                if (!r_len_phase) begin
                    r_len_hi    <= i_rx_data;
                    r_len_phase <= 1'b1;
                end else begin
                    r_len       <= w_len_full;
                    r_len_phase <= 1'b0;
                end
            end
            if (w_word_done) begin
                r_word_cnt <= w_word_cnt_inc;
            end
            if (w_wr_en) begin
                r_addr <= r_addr + c_ADDR_ONE;
            end
`ifdef LOADER_CHECKSUM_EN
            if (w_accept) begin
                r_csum <= r_csum ^ i_rx_data;
            end
`endif
            // A new load wins over a final write landing in the same cycle
            if (w_start) begin
                r_len_phase <= 1'b0;
                r_word_cnt  <= '0;
                r_addr      <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum      <= '0;
`endif
            end
        end
    end

    assign o_rx_ready     = r_rx_ready;
    assign o_imem_wr_en   = w_wr_en;
    assign o_imem_wr_addr = r_addr;
    assign o_imem_wr_data = w_wr_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Self-checking bench for instr_mem_loader against a stream-level
//            reference model. Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        o_rx_ready, o_imem_wr_en, o_busy, o_done, o_error;
    logic [7:0]  o_imem_wr_addr;
    logic [31:0] o_imem_wr_data;

    instr_mem_loader #(
        .DATA_WIDTH_P (32),
        .BYTE_WIDTH_P (8),
        .ADDR_WIDTH_P (ADDR_W),
        .LEN_WIDTH_P  (16)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_rx_ready     (o_rx_ready),
        .o_imem_wr_en   (o_imem_wr_en),
        .o_imem_wr_addr (o_imem_wr_addr),
        .o_imem_wr_data (o_imem_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor: cycle-stamped record of accepted bytes, writes and done pulses
    int          cyc = 0;
    int          busy_fall_cyc = -1;
    logic        prev_busy = 1'b0;
    int          mon_acc_cyc[$];
    logic [7:0]  mon_acc_data[$];
    int          mon_wr_cyc[$];
    logic [7:0]  mon_wr_addr[$];
    logic [31:0] mon_wr_data[$];
    int          mon_done_cyc[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && rx_valid && o_rx_ready) begin
            mon_acc_cyc.push_back(cyc);
            mon_acc_data.push_back(rx_data);
        end
        if (o_imem_wr_en) begin
            mon_wr_cyc.push_back(cyc);
            mon_wr_addr.push_back(o_imem_wr_addr);
            mon_wr_data.push_back(o_imem_wr_data);
        end
        if (o_done) mon_done_cyc.push_back(cyc);
        if (prev_busy && !o_busy) busy_fall_cyc = cyc;
        prev_busy = o_busy;
    end

    // Reference model state
    logic [7:0]  stream_q[$];
    logic [31:0] exp_words[$];
    bit          exp_ok;
    int          exp_end;

    task automatic clear_mon();
        mon_acc_cyc.delete();  mon_acc_data.delete();
        mon_wr_cyc.delete();   mon_wr_addr.delete(); mon_wr_data.delete();
        mon_done_cyc.delete(); busy_fall_cyc = -1;
    endtask

    function automatic int acc_at(input int i);
        if (i >= 0 && i < mon_acc_cyc.size()) return mon_acc_cyc[i];
        return -1000;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0: op = c_OP_RTYPE;
            1: op = c_OP_LW;
            2: op = c_OP_SW;
            3: op = c_OP_BEQ;
            4: op = c_OP_ADDI;
            default: op = c_OP_JUMP;
        endcase
        return {op, 26'($urandom)};
    endfunction

`ifdef LOADER_CHECKSUM_EN
    task automatic append_csum(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'h00;
        foreach (stream_q[i]) x = x ^ stream_q[i];
        stream_q.push_back(x ^ flip);
    endtask
`endif

    task automatic build_stream(input int n);
        logic [31:0] w;
        logic [15:0] n16;
        n16 = 16'(n);
        stream_q.delete();
        stream_q.push_back(n16[15:8]);
        stream_q.push_back(n16[7:0]);
        for (int k = 0; k < n; k++) begin
            w = rand_instr();
            stream_q.push_back(w[31:24]); stream_q.push_back(w[23:16]);
            stream_q.push_back(w[15:8]);  stream_q.push_back(w[7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        append_csum(8'h00);
`endif
    endtask

    // Stream-level reading of the protocol: what should be written and how it ends
    task automatic model_stream();
        int n;
        logic [7:0] x;
        n = int'({stream_q[0], stream_q[1]});
        exp_words.delete();
        exp_ok = 1'b1;
        if (n == 0) begin
            exp_end = 1;
        end else if (n > (1 << ADDR_W)) begin
            exp_ok  = 1'b0;
            exp_end = 1;
        end else begin
            for (int k = 0; k < n; k++)
                exp_words.push_back({stream_q[2+4*k], stream_q[3+4*k],
                                     stream_q[4+4*k], stream_q[5+4*k]});
            exp_end = 1 + 4 * n;
`ifdef LOADER_CHECKSUM_EN
            x = 8'h00;
            for (int i = 0; i <= exp_end; i++) x = x ^ stream_q[i];
            exp_end = exp_end + 1;
            exp_ok  = (stream_q[exp_end] == x);
`else
            x = 8'h00;
`endif
        end
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_rx_ready !== 1'b1 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL start_state: busy/ready/error = %b%b%b, required 110", o_busy, o_rx_ready, o_error);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit glitch);
        bit ok;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        if (glitch) start = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = (o_rx_ready === 1'b1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout: byte %h not accepted, o_rx_ready=%b required 1", b, o_rx_ready);
        end
    endtask

    task automatic run_load(input int max_gap, input int glitch_idx);
        clear_mon();
        model_stream();
        start_load();
        for (int i = 0; i < stream_q.size(); i++)
            send_byte(stream_q[i], int'($urandom_range(0, max_gap)), i == glitch_idx);
        repeat (5) begin @(posedge clk); #1; end

        checks++;
        if (mon_acc_cyc.size() != exp_end + 1) begin
            errors++;
            $display("FAIL accept_count: got %0d bytes accepted, required %0d", mon_acc_cyc.size(), exp_end + 1);
        end
        for (int i = 0; i < mon_acc_data.size() && i < stream_q.size(); i++) begin
            checks++;
            if (mon_acc_data[i] !== stream_q[i]) begin
                errors++;
                $display("FAIL accept_data[%0d]: got %h, required %h", i, mon_acc_data[i], stream_q[i]);
            end
        end
        checks++;
        if (mon_wr_data.size() != exp_words.size()) begin
            errors++;
            $display("FAIL write_count: got %0d writes, required %0d", mon_wr_data.size(), exp_words.size());
        end
        for (int k = 0; k < exp_words.size() && k < mon_wr_data.size(); k++) begin
            checks++;
            if (mon_wr_addr[k] !== 8'(k) || mon_wr_data[k] !== exp_words[k]) begin
                errors++;
                $display("FAIL write[%0d]: got addr %h data %h, required addr %h data %h",
                         k, mon_wr_addr[k], mon_wr_data[k], 8'(k), exp_words[k]);
            end
            checks++;
            if (mon_wr_cyc[k] != acc_at(5 + 4 * k) + 1) begin
                errors++;
                $display("FAIL write_timing[%0d]: got cycle %0d, required %0d", k, mon_wr_cyc[k], acc_at(5 + 4 * k) + 1);
            end
        end
        checks++;
        if (mon_done_cyc.size() != (exp_ok ? 1 : 0)) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, required %0d", mon_done_cyc.size(), exp_ok ? 1 : 0);
        end
        if (exp_ok && mon_done_cyc.size() > 0) begin
            checks++;
            if (mon_done_cyc[0] != acc_at(exp_end) + 1) begin
                errors++;
                $display("FAIL done_timing: got cycle %0d, required %0d", mon_done_cyc[0], acc_at(exp_end) + 1);
            end
        end
        checks++;
        if (busy_fall_cyc != acc_at(exp_end) + 1 + (exp_ok ? 1 : 0)) begin
            errors++;
            $display("FAIL busy_fall: got cycle %0d, required %0d", busy_fall_cyc, acc_at(exp_end) + 1 + (exp_ok ? 1 : 0));
        end
        checks++;
        if (o_error !== !exp_ok || o_busy !== 1'b0 || o_rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL end_state: error/busy/ready = %b%b%b, required %b00", o_error, o_busy, o_rx_ready, !exp_ok);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_write_port: got en %b addr %h data %h, required all 0", o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data);
        end
        checks++;
        if ({o_busy, o_done, o_error, o_rx_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: busy/done/error/ready = %b%b%b%b, required 0000", o_busy, o_done, o_error, o_rx_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_load(input int max_gap);
        stream_q = '{8'h00, 8'h02, 8'h8C, 8'h08, 8'h00, 8'h04, 8'h20, 8'h09, 8'h00, 8'h05};
`ifdef LOADER_CHECKSUM_EN
        append_csum(8'h00);
`endif
        run_load(max_gap, -1);
        checks++;
        if (mon_wr_data.size() != 2 || mon_wr_data[0] !== 32'h8C080004 || mon_wr_data[1] !== 32'h20090005) begin
            errors++;
            $display("FAIL basic_words: got %0d writes, first %h, required 2 writes 8c080004 20090005",
                     mon_wr_data.size(), (mon_wr_data.size() > 0) ? mon_wr_data[0] : 32'h0);
        end
    endtask

    task automatic test_zero_length();
        stream_q = '{8'h00, 8'h00};
        run_load(0, -1);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        checks++;
        if (mon_acc_cyc.size() != 2 || mon_wr_cyc.size() != 0) begin
            errors++;
            $display("FAIL zero_len_idle_rx: got %0d accepts %0d writes, required 2 accepts 0 writes", mon_acc_cyc.size(), mon_wr_cyc.size());
        end
    endtask

    task automatic test_overflow();
        stream_q = '{8'h01, 8'h01};
        run_load(0, -1);
        build_stream(1 << ADDR_W);
        run_load(0, -1);
        checks++;
        if (mon_wr_addr.size() == 0 || mon_wr_addr[mon_wr_addr.size()-1] !== 8'hFF) begin
            errors++;
            $display("FAIL full_load_last_addr: got %h, required ff",
                     (mon_wr_addr.size() > 0) ? mon_wr_addr[mon_wr_addr.size()-1] : 8'h00);
        end
    endtask

    task automatic test_reset_mid_load();
        build_stream(3);
        clear_mon();
        start_load();
        for (int i = 0; i < 4; i++) send_byte(stream_q[i], 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_imem_wr_en, o_busy, o_done, o_error, o_rx_ready} !== 5'b00000 || o_imem_wr_addr !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: en/busy/done/error/ready = %b%b%b%b%b addr %h, required 00000 addr 00",
                     o_imem_wr_en, o_busy, o_done, o_error, o_rx_ready, o_imem_wr_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mon_wr_cyc.size() != 0) begin
            errors++;
            $display("FAIL reset_partial_write: got %0d writes, required 0", mon_wr_cyc.size());
        end
        build_stream(2);
        run_load(1, -1);
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 6; r++) begin
            build_stream(int'($urandom_range(1, 6)));
            run_load(3, int'($urandom_range(3, 9)));
        end
    endtask

    task automatic test_back_to_back();
        build_stream(3);
        run_load(0, -1);
        build_stream(1);
        run_load(0, -1);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stream_q = '{8'h00, 8'h02, 8'h8C, 8'h08, 8'h00, 8'h04, 8'h20, 8'h09, 8'h00, 8'h05};
        append_csum(8'h01);
        run_load(0, -1);
        checks++;
        if (o_error !== 1'b1 || mon_done_cyc.size() != 0 || mon_wr_data.size() != 2) begin
            errors++;
            $display("FAIL csum_mismatch: error %b done %0d writes %0d, required error 1 done 0 writes 2",
                     o_error, mon_done_cyc.size(), mon_wr_data.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load(0);
        test_basic_load(3);
        test_zero_length();
        test_overflow();
        test_reset_mid_load();
        test_back_to_back();
        test_random_loads();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
        test_basic_load(2);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
